// File: rtl/tdc_result_reader.sv
// Polls the TDC result-FIFO empty flags after configuration, reads registers 8/9 and streams
// each 28-bit word with its channel tag; one bus cycle in flight, held off while a result is pending.
module tdc_result_reader #(
    parameter int RD_LOW_CYCLES  = 2,
    parameter int RECOVER_CYCLES = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init_flag,
    input  logic             ef1,
    input  logic             ef2,
    input  logic [27:0]      tdc_data,
    output logic [3:0]       addr,
    output logic             CSN,
    output logic             RDN,
    output logic             bus_req,
    output logic [27:0]      result_data,
    output logic             result_ch,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] result_count
);

    typedef enum logic [2:0] {IDLE, ARB, SETUP, STROBE, HOLD, RECOVER, PRESENT} state_t;

    localparam logic [7:0] RD_LAST  = 8'(RD_LOW_CYCLES - 1);
    localparam logic [7:0] REC_LAST = 8'(RECOVER_CYCLES - 1);

    state_t           state_q;
    logic [7:0]       cyc_q;
    logic             sel_ch_q;
    logic             last_ch_q;
    logic             abort_q;
    logic [3:0]       addr_q;
    logic             csn_q;
    logic             rdn_q;
    logic             bus_req_q;
    logic [27:0]      result_data_q;
    logic             result_ch_q;
    logic             result_valid_q;
    logic [CNT_W-1:0] result_count_q;
    logic [CNT_W-1:0] result_count_d;

    logic arb_hit;
    logic arb_ch;

    // Both FIFOs holding data: alternate away from the last channel served.
    assign arb_hit        = ~(ef1 & ef2);
    assign arb_ch         = (~ef1 & ~ef2) ? ~last_ch_q : ef1;
    assign result_count_d = result_count_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cyc_q          <= 8'd0;
            sel_ch_q       <= 1'b0;
            last_ch_q      <= 1'b1;
            abort_q        <= 1'b0;
            addr_q         <= 4'hf;
            csn_q          <= 1'b1;
            rdn_q          <= 1'b1;
            bus_req_q      <= 1'b0;
            result_data_q  <= 28'd0;
            result_ch_q    <= 1'b0;
            result_valid_q <= 1'b0;
            result_count_q <= '0;
        end else begin
            // A re-init seen anywhere after selection is remembered until the cycle completes.
            if (init_flag && state_q != IDLE && state_q != ARB) begin
                abort_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    addr_q    <= 4'hf;
                    bus_req_q <= 1'b0;
                    abort_q   <= 1'b0;
                    if (!init_flag) begin
                        state_q <= ARB;
                    end
                end
                ARB: begin
                    if (init_flag) begin
                        state_q <= IDLE;
                    end else if (arb_hit) begin
                        sel_ch_q  <= arb_ch;
                        addr_q    <= arb_ch ? 4'd9 : 4'd8;
                        bus_req_q <= 1'b1;
                        csn_q     <= 1'b0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    rdn_q   <= 1'b0;
                    cyc_q   <= 8'd0;
                    state_q <= STROBE;
                end
                STROBE: begin
                    if (cyc_q == RD_LAST) begin
                        result_data_q <= tdc_data;
                        rdn_q         <= 1'b1;
                        state_q       <= HOLD;
                    end else begin
                        cyc_q <= cyc_q + 8'd1;
                    end
                end
                HOLD: begin
                    csn_q     <= 1'b1;
                    addr_q    <= 4'hf;
                    bus_req_q <= 1'b0;
                    cyc_q     <= 8'd0;
                    state_q   <= RECOVER;
                end
                RECOVER: begin
                    if (cyc_q == REC_LAST) begin
                        if (abort_q || init_flag) begin
                            state_q <= IDLE;
                        end else begin
                            result_ch_q    <= sel_ch_q;
                            last_ch_q      <= sel_ch_q;
                            result_valid_q <= 1'b1;
                            state_q        <= PRESENT;
                        end
                    end else begin
                        cyc_q <= cyc_q + 8'd1;
                    end
                end
                PRESENT: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        result_count_q <= result_count_d;
                        abort_q        <= 1'b0;
                        state_q        <= (abort_q || init_flag) ? IDLE : ARB;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addr         = addr_q;
    assign CSN          = csn_q;
    assign RDN          = rdn_q;
    assign bus_req      = bus_req_q;
    assign result_data  = result_data_q;
    assign result_ch    = result_ch_q;
    assign result_valid = result_valid_q;
    assign result_count = result_count_q;

endmodule

// File: tb/tb_tdc_result_reader.sv
// Directed bench for tdc_result_reader: vector table of reads plus hand sequences for corner cases.
module tb_tdc_result_reader;

    logic        clk = 1'b0;
    logic        reset, init_flag, ef1, ef2, result_ready;
    logic [27:0] tdc_data;
    logic [3:0]  addr;
    logic        CSN, RDN, bus_req, result_ch, result_valid;
    logic [27:0] result_data;
    logic [15:0] result_count;

    logic [3:0]  s_addr;
    logic        s_csn, s_rdn, s_bus, s_ch, s_valid;
    logic [27:0] s_data;
    logic [3:0]  s_count;

    int          vectors = 0;
    int          errors  = 0;
    logic [15:0] exp_count = 16'd0;

    always #5 clk = ~clk;

    tdc_result_reader dut (
        .clk(clk), .reset(reset), .init_flag(init_flag), .ef1(ef1), .ef2(ef2),
        .tdc_data(tdc_data), .addr(addr), .CSN(CSN), .RDN(RDN), .bus_req(bus_req),
        .result_data(result_data), .result_ch(result_ch), .result_valid(result_valid),
        .result_ready(result_ready), .result_count(result_count)
    );

    tdc_result_reader #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .init_flag(init_flag), .ef1(ef1), .ef2(ef2),
        .tdc_data(tdc_data), .addr(s_addr), .CSN(s_csn), .RDN(s_rdn), .bus_req(s_bus),
        .result_data(s_data), .result_ch(s_ch), .result_valid(s_valid),
        .result_ready(result_ready), .result_count(s_count)
    );

    always @(negedge clk) begin
        if (CSN && !RDN) begin
            errors++;
            $display("FAIL strobe_rule: CSN=%0b RDN=%0b", CSN, RDN);
        end
        if ({s_addr, s_csn, s_rdn, s_bus, s_data, s_ch, s_valid} !==
            {addr, CSN, RDN, bus_req, result_data, result_ch, result_valid}) begin
            errors++;
            $display("FAIL twin_match: CNT_W=4 instance outputs diverge");
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    typedef struct {
        logic        ef1;
        logic        ef2;
        logic [27:0] data;
        logic        ch;
    } vec_t;

    vec_t vecs[9];

    task automatic do_read(input vec_t v);
        int   csn_cnt = 0, rdn_cnt = 0, lat = 0;
        bit   seen = 1'b0, ok = 1'b0;
        logic [3:0] a = 4'hf;
        @(negedge clk);
        ef1 = v.ef1; ef2 = v.ef2; tdc_data = v.data; result_ready = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!CSN) begin
                if (!seen) a = addr;
                seen = 1'b1;
                csn_cnt++;
            end
            if (!RDN) rdn_cnt++;
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
            if (seen) lat++;
        end
        ef1 = 1'b1; ef2 = 1'b1;
        check("read_done", {31'd0, ok}, 32'd1);
        check("read_addr", {28'd0, a}, {28'd0, 4'd8 + {3'd0, v.ch}});
        check("csn_window", csn_cnt, 4);
        check("rdn_window", rdn_cnt, 2);
        check("latency", lat, 5);
        check("result_data", {4'd0, result_data}, {4'd0, v.data});
        check("result_ch", {31'd0, result_ch}, {31'd0, v.ch});
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        exp_count++;
        check("valid_drop", {31'd0, result_valid}, 32'd0);
        check("count", {16'd0, result_count}, {16'd0, exp_count});
    endtask

    initial begin
        bit          ok;
        bit          bad;
        int          cnt;
        int          pulses, last_t, gap;
        logic [27:0] held;

        vecs[0] = '{1'b0, 1'b0, 28'h012_3456, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 28'hA5A_5A5A, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 28'hFFF_FFFF, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 28'h000_0001, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 28'h123_4567, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 28'h765_4321, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 28'h0C0_FFEE, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 28'hBAD_F00D, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 28'h012_3456, 1'b0};

        reset = 1'b1; init_flag = 1'b1; ef1 = 1'b1; ef2 = 1'b1;
        result_ready = 1'b0; tdc_data = 28'd0;
        repeat (2) @(negedge clk);
        check("rst_addr", {28'd0, addr}, 32'hf);
        check("rst_csn_rdn_bus", {29'd0, CSN, RDN, bus_req}, 32'b110);
        check("rst_valid_ch", {30'd0, result_valid, result_ch}, 32'd0);
        check("rst_data", {4'd0, result_data}, 32'd0);
        check("rst_count", {16'd0, result_count}, 32'd0);
        reset = 1'b0;

        // Configuration in progress: FIFOs report data but the bus must stay idle.
        ef1 = 1'b0; ef2 = 1'b0; bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (!CSN || !RDN || bus_req || addr != 4'hf) bad = 1'b1;
        end
        check("gating_idle", {31'd0, bad}, 32'd0);
        init_flag = 1'b0;

        for (int i = 0; i < 9; i++) do_read(vecs[i]);

        // Back-pressure: result held, no new bus cycle, fresh bus data ignored.
        ef1 = 1'b0; ef2 = 1'b1; tdc_data = 28'h0AB_CDEF;
        wait_valid("bp", ok);
        held = 28'h0AB_CDEF;
        tdc_data = 28'h111_1111; bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!result_valid || result_data != held || !CSN || bus_req) bad = 1'b1;
        end
        check("bp_hold", {31'd0, bad}, 32'd0);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        exp_count++;
        check("bp_count", {16'd0, result_count}, {16'd0, exp_count});
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!CSN) begin ok = 1'b1; break; end
        end
        check("bp_next_read", {31'd0, ok}, 32'd1);
        wait_valid("bp2", ok);
        ef1 = 1'b1;
        check("bp2_data", {4'd0, result_data}, 32'h111_1111);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        exp_count++;

        // Re-init during STROBE: strobe completes, word discarded, block parks.
        ef1 = 1'b0; ef2 = 1'b1; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!RDN) begin ok = 1'b1; break; end
        end
        check("reinit_strobe_seen", {31'd0, ok}, 32'd1);
        init_flag = 1'b1; ef1 = 1'b0; ef2 = 1'b0;
        cnt = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (RDN) break;
            cnt++;
        end
        check("reinit_rdn_len", cnt, 2);
        bad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (result_valid) bad = 1'b1;
        end
        check("reinit_no_valid", {31'd0, bad}, 32'd0);
        check("reinit_parked", {29'd0, CSN, RDN, bus_req}, 32'b110);
        check("reinit_count", {16'd0, result_count}, {16'd0, exp_count});
        ef1 = 1'b1; ef2 = 1'b1; init_flag = 1'b0;

        // Re-init while presenting: result still delivered, then idle.
        ef1 = 1'b0;
        wait_valid("pres", ok);
        init_flag = 1'b1; ef1 = 1'b0; ef2 = 1'b0;
        repeat (3) @(negedge clk);
        check("pres_held", {31'd0, result_valid}, 32'd1);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        exp_count++;
        check("pres_count", {16'd0, result_count}, {16'd0, exp_count});
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (!CSN || result_valid) bad = 1'b1;
        end
        check("pres_then_idle", {31'd0, bad}, 32'd0);
        ef1 = 1'b1; ef2 = 1'b1; init_flag = 1'b0;

        // Reset mid-STROBE releases the strobes on the next edge.
        ef1 = 1'b0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!RDN) begin ok = 1'b1; break; end
        end
        check("rst_strobe_seen", {31'd0, ok}, 32'd1);
        reset = 1'b1; ef1 = 1'b1;
        @(negedge clk);
        check("rst_mid_pins", {27'd0, addr, CSN, RDN, bus_req}, {27'd0, 4'hf, 3'b110});
        check("rst_mid_count", {16'd0, result_count}, 32'd0);
        reset = 1'b0;
        exp_count = 16'd0;

        // Sixteen back-to-back results: ARB-to-ARB spacing and 4-bit counter wrap.
        ef1 = 1'b0; ef2 = 1'b0; result_ready = 1'b1;
        pulses = 0; last_t = 0; gap = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (result_valid) begin
                pulses++;
                gap = t - last_t;
                last_t = t;
                if (pulses == 16) break;
            end
        end
        ef1 = 1'b1; ef2 = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        @(negedge clk);
        check("b2b_pulses", pulses, 16);
        check("b2b_spacing", gap, 7);
        check("wrap_count16", {16'd0, result_count}, 32'd16);
        check("wrap_count4", {28'd0, s_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
